// File: rtl/aes_round_ctrl.sv
// Round sequencer for the iterative AES-128 datapath: init, ten rounds spaced LAT+1 cycles, ciphertext capture.
// Issues only enables, round number and round constant; all outputs are registered.
module aes_round_ctrl #(
  parameter int LAT = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  output logic [3:0] round,
  output logic [7:0] rcon,
  output logic       init_en,
  output logic       step_en,
  output logic       final_rnd,
  output logic       ct_en,
  output logic       busy,
  output logic       done
);

  typedef enum logic [2:0] {IDLE, INIT, WAIT, STEP, DONE} state_t;

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_t     state;
  logic [3:0] cnt;
  logic       ls1, ls2, ls3;
  logic       fall, rise;

  assign fall = ls3 & ~ls2;
  assign rise = ~ls3 & ls2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ls1       <= 1'b0;
      ls2       <= 1'b0;
      ls3       <= 1'b0;
      state     <= IDLE;
      cnt       <= 4'd0;
      round     <= 4'd0;
      rcon      <= 8'h00;
      init_en   <= 1'b0;
      step_en   <= 1'b0;
      ct_en     <= 1'b0;
      final_rnd <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      ls1     <= load;
      ls2     <= ls1;
      ls3     <= ls2;
      init_en <= 1'b0;
      step_en <= 1'b0;
      ct_en   <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            state   <= INIT;
            init_en <= 1'b1;
            busy    <= 1'b1;
          end
        end

        INIT, WAIT, STEP: begin
          if (rise) begin
            // Host re-asserted load mid-run: drop the run without further pulses.
            state     <= IDLE;
            cnt       <= 4'd0;
            round     <= 4'd0;
            rcon      <= 8'h00;
            final_rnd <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
          end else if (state == INIT) begin
            state <= WAIT;
            round <= 4'd1;
            rcon  <= 8'h01;
            cnt   <= CNT_INIT;
          end else if (state == WAIT) begin
            if (cnt != 4'd0) begin
              cnt <= cnt - 4'd1;
            end else begin
              state   <= STEP;
              step_en <= (round != 4'd10);
              ct_en   <= (round == 4'd10);
            end
          end else if (round != 4'd10) begin
            state     <= WAIT;
            round     <= round + 4'd1;
            // GF(2^8) doubling: 80 -> 1B -> 36 for the last two rounds.
            rcon      <= {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
            final_rnd <= (round == 4'd9);
            cnt       <= CNT_INIT;
          end else begin
            state     <= DONE;
            final_rnd <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end

        DONE: begin
          if (rise) begin
            state <= IDLE;
            done  <= 1'b0;
            round <= 4'd0;
            rcon  <= 8'h00;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Directed bench for aes_round_ctrl: LAT=3 and LAT=1 instances driven by one load line, checked cycle by cycle.
module tb_aes_round_ctrl;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [3:0] round3, round1;
  logic [7:0] rcon3, rcon1;
  logic       init3, step3, fin3, ct3, busy3, done3;
  logic       init1, step1, fin1, ct1, busy1, done1;

  int vectors;
  int miscompares;

  aes_round_ctrl #(.LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .load(load), .round(round3), .rcon(rcon3),
    .init_en(init3), .step_en(step3), .final_rnd(fin3), .ct_en(ct3),
    .busy(busy3), .done(done3)
  );

  aes_round_ctrl #(.LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .load(load), .round(round1), .rcon(rcon1),
    .init_en(init1), .step_en(step1), .final_rnd(fin1), .ct_en(ct1),
    .busy(busy1), .done(done1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] obs3();
    return {init3, step3, ct3, fin3, busy3, done3, round3, rcon3};
  endfunction

  function automatic logic [17:0] obs1();
    return {init1, step1, ct1, fin1, busy1, done1, round1, rcon1};
  endfunction

  function automatic logic [7:0] rcon_tab(input int r);
    case (r)
      1: return 8'h01;   2: return 8'h02;   3: return 8'h04;   4: return 8'h08;
      5: return 8'h10;   6: return 8'h20;   7: return 8'h40;   8: return 8'h80;
      9: return 8'h1b;  10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  // Expected {init,step,ct,final,busy,done,round,rcon} at cycle t after INIT.
  function automatic logic [17:0] exp_vec(input int lat, input int t);
    int l;
    int r;
    l = lat + 1;
    if (t == 0) return {6'b100010, 4'd0, 8'h00};
    if (t > 10 * l) return {6'b000001, 4'd10, 8'h36};
    r = (t - 1) / l + 1;
    return {1'b0, (t % l == 0) && (t < 10 * l), t == 10 * l, r == 10, 1'b1, 1'b0,
            4'(r), rcon_tab(r)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_l3_%0d", tag, i), obs3(), 18'h0);
      check($sformatf("%s_l1_%0d", tag, i), obs1(), 18'h0);
      tick();
    end
  endtask

  // load must have just been driven low; abort_at >= 0 raises load after that cycle.
  task automatic run(input string tag, input int ncyc, input int abort_at);
    logic [17:0] e3, e1;
    repeat (3) tick();
    for (int t = 0; t < ncyc; t++) begin
      e3 = exp_vec(3, t);
      e1 = exp_vec(1, t);
      if (abort_at >= 0 && t >= abort_at + 3) begin
        e3 = 18'h0;
        e1 = 18'h0;
      end
      check($sformatf("%s_l3_t%0d", tag, t), obs3(), e3);
      check($sformatf("%s_l1_t%0d", tag, t), obs1(), e1);
      if (t == abort_at) load = 1'b1;
      tick();
    end
  endtask

  // From DONE with load low: raise load, done holds two edges then clears.
  task automatic clear_done(input string tag);
    load = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check($sformatf("%s_hold_l3_%0d", tag, i), obs3(), exp_vec(3, 999));
      check($sformatf("%s_hold_l1_%0d", tag, i), obs1(), exp_vec(1, 999));
    end
    tick();
    check($sformatf("%s_clr_l3", tag), obs3(), 18'h0);
    check($sformatf("%s_clr_l1", tag), obs1(), 18'h0);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    load        = 1'b0;
    #1;
    check("reset_l3", obs3(), 18'h0);
    check("reset_l1", obs1(), 18'h0);
    repeat (3) tick();
    rst_n = 1'b1;

    // Reset asserted mid-WAIT clears everything without a clock edge.
    load = 1'b1;
    repeat (10) tick();
    load = 1'b0;
    repeat (5) tick();
    check("pre_reset_busy_l3", obs3(), exp_vec(3, 2));
    rst_n = 1'b0;
    #2;
    check("midrun_reset_l3", obs3(), 18'h0);
    check("midrun_reset_l1", obs1(), 18'h0);
    rst_n = 1'b1;
    tick();
    check_idle("post_reset", 50);

    // Nominal run, done held for 100 cycles.
    load = 1'b1;
    check_idle("load_high", 10);
    load = 1'b0;
    run("nominal", 141, -1);

    clear_done("clear1");
    load = 1'b1;
    check_idle("rerun_pre", 4);
    load = 1'b0;
    run("rerun", 50, -1);

    // Abort in round 4 of the LAT=3 run, then full restart.
    clear_done("clear2");
    check_idle("abort_pre", 4);
    load = 1'b0;
    run("abort", 40, 12);
    load = 1'b0;
    run("restart", 50, -1);

    // One-cycle low glitch: a single INIT, then abort on the re-rise.
    clear_done("clear3");
    check_idle("glitch_pre", 3);
    load = 1'b0;
    tick();
    check("glitch_e0_l3", obs3(), 18'h0);
    load = 1'b1;
    tick();
    check("glitch_e1_l3", obs3(), 18'h0);
    check("glitch_e1_l1", obs1(), 18'h0);
    tick();
    check("glitch_init_l3", obs3(), exp_vec(3, 0));
    check("glitch_init_l1", obs1(), exp_vec(1, 0));
    tick();
    check_idle("glitch_post", 20);

    // Short high pulse in DONE: rise then fall gives exactly one new run.
    load = 1'b0;
    run("pre_pulse", 45, -1);
    load = 1'b1;
    tick();
    check("pulse_e0_l3", obs3(), exp_vec(3, 999));
    load = 1'b0;
    run("pulse_run", 70, -1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
# aes_round_ctrl

Round sequencer for the iterative AES-128 encryption datapath on the FPGA. It watches the host `load` strobe and detects the end of a load. It then drives one shared, registered round datapath through the initial AddRoundKey and rounds 1–10, and asserts `done` for the SPI block when the ciphertext is captured. The block holds no data registers; it only issues enables, the round number and the round constant.

## Interface
Parameters:
- `LAT`, default 3: clock cycles from a state/key register update to a valid round output (sync sbox + shiftRows reg + mixcolumns reg). Legal range 1..15.

Ports:
- `clk` input 1: core clock from the HSOSC divider.
- `rst_n` input 1: reset, asynchronous, active-low.
- `load` input 1: host load strobe, asynchronous to `clk`. It is high while the key and plaintext are shifted in, and its falling edge starts an encryption.
- `round` output 4: current round number (0..10) to the key-expansion and round logic.
- `rcon` output 8: round constant byte for `round`.
- `init_en` output 1: one-cycle pulse that loads state reg ← plaintext ^ key and key reg ← key.
- `step_en` output 1: one-cycle pulse that loads state reg ← round output and key reg ← expanded key.
- `final_rnd` output 1: high while `round`==10. The datapath bypasses mixcolumns while it is high.
- `ct_en` output 1: one-cycle pulse that captures the ciphertext from the round-10 output.
- `busy` output 1: high from INIT through the last STEP.
- `done` output 1: ciphertext valid.

## Operation
- `load` passes through a 2-flop synchronizer (`ls1`, `ls2`), then a delay flop `ls3`.
  - fall = `ls3 & ~ls2`.
  - rise = `~ls3 & ls2`.
  - All three flops reset to 0.
- FSM states: IDLE, INIT, WAIT, STEP, DONE. A down-counter `cnt` (4 bits) runs in WAIT.
- IDLE:
  - Outputs: `busy`=0, `round`=0.
  - On fall, go to INIT.
- INIT (1 cycle):
  - Outputs: `init_en`=1, `busy`=1, `round`=0.
  - Next: WAIT with `round`←1 and `cnt`←LAT−1.
- WAIT:
  - While `cnt`≠0: decrement `cnt`.
  - When `cnt`==0: go to STEP.
- STEP (1 cycle), when `round`<10:
  - `step_en`=1, `round`←`round`+1, `cnt`←LAT−1.
  - Next: WAIT.
- STEP (1 cycle), when `round`==10:
  - `ct_en`=1.
  - Next: DONE; `round` holds at 10.
- DONE:
  - Outputs: `done`=1, `busy`=0.
  - Holds until rise. On rise, go to IDLE; `done`=0 and `round`=0 from the next cycle.
- Abort: a rise in INIT, WAIT or STEP goes to IDLE.
  - No further `step_en` or `ct_en` is issued.
  - `done` stays 0.
- Fall outside IDLE: ignored. A fall cannot reach WAIT, STEP or DONE without a preceding rise, which has already forced IDLE.
- `rcon` mapping:
  - Rounds 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36.
  - Round 0 and IDLE: 00.
  - Implement as a table or as a GF(2^8) doubling register; the outputs must be identical either way.
- `final_rnd` = (`round`==10) while `busy` is high. It is 0 in DONE and IDLE.

## Timing
- Reset (`rst_n`=0) takes effect immediately, asynchronously:
  - state = IDLE, `cnt`=0, `round`=0, `rcon`=00.
  - `init_en`, `step_en`, `ct_en`, `final_rnd`, `busy`, `done` = 0.
  - Synchronizer flops = 0.
  - Reset mid-encryption discards the run; no pulse follows until a new fall.
- Start latency: `load` first sampled low at edge E0 → INIT entered at edge E2.
- Relative to the INIT cycle = cycle 0:
  - Round r (1..10) occupies cycles (r−1)(LAT+1)+1 through r(LAT+1).
  - The last cycle of round r is its STEP.
  - `step_en` fires at cycles k(LAT+1) for k=1..9.
  - `ct_en` fires at cycle 10(LAT+1).
  - `done` rises at cycle 10(LAT+1)+1.
  - For LAT=3: `ct_en` at cycle 40, `done` from cycle 41.
- `round` and `rcon` change only on the edge that ends INIT or STEP. They are stable for all LAT+1 cycles of the round.
- `init_en`, `step_en` and `ct_en` are Moore outputs, at most one of them high in any cycle, each exactly one cycle wide.
- Done clear: `load` sampled high at E0 → rise detected → `done` low after edge E2.

## Test plan
- Reset: assert `rst_n`=0 mid-WAIT → all outputs 0 within the same cycle. Release reset with `load` low → no `init_en` for 50 cycles.
- Nominal, LAT=3: `load` high for 10 cycles, then low → `init_en` at E2 with `rcon`=00.
  - `step_en` at INIT+4, +8, …, +36 (9 pulses).
  - `rcon` sequence 01…36.
  - `final_rnd` high cycles 37–40.
  - `ct_en` at +40; `done`=1 from +41 and held for 100 cycles.
- Done clear and rerun: `load` rises in DONE → `done`=0 two edges later. `load` falls → identical pulse schedule to the nominal run.
- Abort: `load` rises at INIT+15 (round 4) → IDLE, `busy`=0, no `ct_en`, `done` stays 0. The next fall restarts from `round`=0 with full timing.
- Parameter LAT=1: `step_en` at INIT+2, 4, …, 18; `ct_en` at +20; `done` at +21.
- Glitch and spurious edges:
  - A 1-cycle low pulse on `load` while high → exactly one INIT, then abort on the re-rise.
  - A fall while in DONE (forced via a rise then a fall) → exactly one new encryption.
